// File: rtl/circle_track_axil_regs.sv
// AXI4-Lite slave holding four 32-bit configuration registers for the circle-tracking overlay.
// Define CIRCLE_REGS_SHADOW_EN to drive reg*_o from a shadow copy that loads on frame_start.
module circle_track_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            frame_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic                            cfg_update
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic          r_aw_held;
    logic          r_w_held;
    logic          r_bvalid;
    logic [1:0]    r_aw_idx;
    logic [DW-1:0] r_wdata;
    logic [NB-1:0] r_wstrb;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_regs [4];
    logic          r_cfg_update;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_commit;
    logic w_change;
    logic w_unused;

    // NOTE: readies are gated by ARESET so no handshake can be seen while reset is asserted.
    assign S_AXI_AWREADY = !ARESET && !r_aw_held && !r_bvalid;
    assign S_AXI_WREADY  = !ARESET && !r_w_held && !r_bvalid;
    assign S_AXI_ARREADY = !ARESET && !r_rvalid;

    assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_commit = r_aw_held && r_w_held;

    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_RRESP  = 2'b00;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign cfg_update   = r_cfg_update;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Address and data are captured independently; the write commits once both are held.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // NOTE: the register array is small flop storage, so it takes the async reset like any other state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (r_wstrb[b]) begin
                    r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads sample the pre-edge architectural value, so a same-edge commit returns the old data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_regs[S_AXI_ARADDR[3:2]];
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

`ifdef CIRCLE_REGS_SHADOW_EN
    logic [DW-1:0] r_shadow [4];
    logic          r_load_diff;
    logic          w_differs;

    always_comb begin
        w_differs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_shadow[i] != r_regs[i]) begin
                w_differs = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_load_diff <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_load_diff <= frame_start && w_differs;
            if (frame_start) begin
                for (int i = 0; i < 4; i++) begin
                    r_shadow[i] <= r_regs[i];
                end
            end
        end
    end

    assign w_change = r_load_diff;
    assign reg0_o   = r_shadow[0];
    assign reg1_o   = r_shadow[1];
    assign reg2_o   = r_shadow[2];
    assign reg3_o   = r_shadow[3];
`else
    logic r_commit_q;
    logic w_unused_frame;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_commit_q <= 1'b0;
        end else begin
            r_commit_q <= w_commit;
        end
    end

    assign w_unused_frame = frame_start;
    assign w_change       = r_commit_q;
    assign reg0_o         = r_regs[0];
    assign reg1_o         = r_regs[1];
    assign reg2_o         = r_regs[2];
    assign reg3_o         = r_regs[3];
`endif

    // The pulse lands on the edge after the presented values change.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= w_change;
        end
    end

endmodule

// File: doc/circle_track_axil_regs.md
# circle_track_axil_regs

AXI4-Lite slave register file for the circle-tracking overlay. It terminates the PS-side AXI4-Lite master and holds four 32-bit configuration registers. Their values drive the overlay pixel pipeline directly. Write and read paths are independent and each allows one outstanding transaction. An optional shadow stage makes register updates frame-synchronous.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1  write address; AWPROT is ignored. S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data and byte strobes. S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY). S_AXI_BVALID  out  1. S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1  read address; ARPROT is ignored. S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32. S_AXI_RRESP  out  2  always OKAY. S_AXI_RVALID  out  1. S_AXI_RREADY  in  1.
- frame_start  in  1  single-cycle pulse at the start of each video frame.
- reg0_o..reg3_o  out  32 each  register values presented to the overlay logic.
- cfg_update  out  1  one-cycle pulse whenever reg*_o changes.

## Operation
- Write path state:
  - aw_held and w_held flags capture address and data independently, in any order or together.
  - S_AXI_AWREADY = !aw_held && !S_AXI_BVALID; S_AXI_WREADY = !w_held && !S_AXI_BVALID.
- Write commit:
  - Commit happens on the edge following the first cycle in which both flags are set.
  - The selected register updates bytewise per WSTRB (WSTRB=0 leaves it unchanged but still responds).
  - Both flags clear and BVALID sets on that same edge.
  - BVALID holds until BREADY; AW/W readies stay low meanwhile.
- Read path:
  - S_AXI_ARREADY = !S_AXI_RVALID.
  - On an AR handshake, RDATA loads the addressed register's current architectural value and RVALID sets on that same edge.
  - RDATA is stable until the RREADY handshake.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the old value.
  - A read accepted on a later edge returns the new value.
- All four registers are read/write; their reset value is 0.
- Reset mid-transaction:
  - Held flags, BVALID, RVALID and all registers clear immediately.
  - A partially captured write is discarded with no response.
- cfg_update pulses on the edge after reg*_o change.

## Timing
- Reset values: every output is 0, and all READYs are forced 0 while ARESET is high.
- AW and W accepted together at edge N: register written and BVALID high after edge N+1.
- W accepted at edge N, AW at edge N+3: BVALID high after edge N+4.
- Maximum write throughput: one write per 3 cycles (accept, commit, B handshake).
- AR accepted at edge N: RVALID high after edge N, so read latency is 1 cycle. Maximum read throughput: one read per 2 cycles.
- A B handshake and a new AW/W acceptance cannot happen on the same edge; readies rise the cycle after BVALID falls.

## Configuration
- CIRCLE_REGS_SHADOW_EN defined:
  - reg*_o come from a shadow copy loaded from the architectural registers on the edge where frame_start is high.
  - cfg_update pulses the cycle after that load, only if any value differs.
  - AXI reads always return architectural values.
- CIRCLE_REGS_SHADOW_EN undefined:
  - reg*_o equal the architectural registers directly.
  - frame_start is ignored.
  - cfg_update pulses the cycle after each committing write.

## Test plan
- Sequential writes: 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, each with BREADY=1. Read back 0x0..0xC -> RDATA 0x1..0x4, every BRESP/RRESP = 0.
- Out-of-order channels: W (0xDEADBEEF, strobe 0xF) presented 3 cycles before AW=0x8 -> BVALID exactly 1 cycle after AW accepted; reg2_o = 0xDEADBEEF.
- Byte strobes: reg1=0x11223344, write 0xAABBCCDD with strobe 0x5 -> read 0x11BB33DD.
- Backpressure: hold BREADY=0 for 10 cycles -> BVALID stays high and AWREADY/WREADY stay 0 throughout. Hold RREADY=0 -> RDATA stable and ARREADY=0.
- Reset mid-write: AW accepted, W pending, ARESET pulsed -> no BVALID, all registers 0, all READYs low during reset.
- Shadow mode (macro defined): write reg0=0x5 -> reg0_o stays 0 until frame_start; reg0_o=0x5 one cycle after it; cfg_update pulses once.
